// File: rtl/lcd_pkg.sv
// Shared types and default timing for the 8080-style LCD write-bus sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_RST_LOW  = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_IDLE     = 3'd2,
        ST_SETUP    = 3'd3,
        ST_WR_LOW   = 3'd4,
        ST_WR_HIGH  = 3'd5
    } lcd_seq_state_t;

    localparam logic LCD_DCX_CMD  = 1'b0;
    localparam logic LCD_DCX_DATA = 1'b1;

    localparam int LCD_WR_LOW_CYC_DEF   = 2;
    localparam int LCD_WR_HIGH_CYC_DEF  = 2;
    localparam int LCD_RST_LOW_CYC_DEF  = 500;
    localparam int LCD_RST_WAIT_CYC_DEF = 250000;

    function automatic int lcd_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        if (d > m) begin
            m = d;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module lcd_timer #(
    parameter int          W           = 8,
    parameter logic [W-1:0] RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count_r;

    // Count register: load wins over decrement, holds at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= RESET_VALUE;
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {W{1'b0}});

endmodule

// File: rtl/lcd_bus_sequencer.sv
// 8080 parallel LCD write-bus sequencer: panel reset sequence, command/pixel
// arbitration (command wins) and per-word CSX/WRX timing.
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int WR_LOW_CYC   = LCD_WR_LOW_CYC_DEF,
    parameter int WR_HIGH_CYC  = LCD_WR_HIGH_CYC_DEF,
    parameter int RST_LOW_CYC  = LCD_RST_LOW_CYC_DEF,
    parameter int RST_WAIT_CYC = LCD_RST_WAIT_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic        cmd_dcx,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    input  logic        hw_reset_req,
    output logic        busy,
    output logic        lcd_csx,
    output logic        lcd_dcx,
    output logic        lcd_wrx,
    output logic [15:0] lcd_d,
    output logic        lcd_resx
);

    localparam int CNT_W = $clog2(lcd_max4(WR_LOW_CYC, WR_HIGH_CYC,
                                           RST_LOW_CYC, RST_WAIT_CYC)) + 1;

    localparam logic [CNT_W-1:0] RST_LOW_LD  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RST_WAIT_LD = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LOW_LD   = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WR_HIGH_LD  = CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LD    = {CNT_W{1'b0}};

    lcd_seq_state_t   state_r;
    lcd_seq_state_t   state_s;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_value_s;
    logic             tmr_done_s;
    logic             cmd_fire_s;
    logic             pix_fire_s;
    logic             pending_r;
    logic             in_word_s;
    logic             csx_r;
    logic             wrx_r;
    logic             resx_r;
    logic             dcx_r;
    logic [15:0]      d_r;
    logic             busy_r;

    lcd_timer #(
        .W           (CNT_W),
        .RESET_VALUE (RST_LOW_LD)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load_s),
        .load_value (tmr_value_s),
        .done       (tmr_done_s)
    );

    // Next-state, timer load and handshake decode.
    always_comb begin
        state_s     = state_r;
        tmr_load_s  = 1'b0;
        tmr_value_s = {CNT_W{1'b0}};
        cmd_fire_s  = 1'b0;
        pix_fire_s  = 1'b0;
        cmd_ready   = 1'b0;
        pix_ready   = 1'b0;
        case (state_r)
            ST_RST_LOW: begin
                if (tmr_done_s) begin
                    state_s     = ST_RST_WAIT;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = RST_WAIT_LD;
                end else begin
                    state_s = ST_RST_LOW;
                end
            end
            ST_RST_WAIT: begin
                if (tmr_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RST_WAIT;
                end
            end
            ST_IDLE: begin
                // A reset request suppresses both readies so no word is lost.
                if (hw_reset_req) begin
                    state_s     = ST_RST_LOW;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = RST_LOW_LD;
                end else begin
                    cmd_ready = 1'b1;
                    pix_ready = !cmd_valid;
                    if (cmd_valid) begin
                        cmd_fire_s  = 1'b1;
                        state_s     = ST_SETUP;
                        tmr_load_s  = 1'b1;
                        tmr_value_s = SETUP_LD;
                    end else if (pix_valid) begin
                        pix_fire_s  = 1'b1;
                        state_s     = ST_SETUP;
                        tmr_load_s  = 1'b1;
                        tmr_value_s = SETUP_LD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_done_s) begin
                    state_s     = ST_WR_LOW;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = WR_LOW_LD;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_WR_LOW: begin
                if (tmr_done_s) begin
                    state_s     = ST_WR_HIGH;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = WR_HIGH_LD;
                end else begin
                    state_s = ST_WR_LOW;
                end
            end
            ST_WR_HIGH: begin
                if (!tmr_done_s) begin
                    state_s = ST_WR_HIGH;
                end else if (pending_r || hw_reset_req) begin
                    state_s     = ST_RST_LOW;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = RST_LOW_LD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s     = ST_RST_LOW;
                tmr_load_s  = 1'b1;
                tmr_value_s = RST_LOW_LD;
            end
        endcase
    end

    assign in_word_s = (state_r == ST_SETUP) || (state_r == ST_WR_LOW) ||
                       (state_r == ST_WR_HIGH);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RST_LOW;
        end else begin
            state_r <= state_s;
        end
    end

    // Deferred reset request: remembered during a word, dropped on RST_LOW entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= 1'b0;
        end else if (state_s == ST_RST_LOW) begin
            pending_r <= 1'b0;
        end else if (hw_reset_req && in_word_s) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Bus pins are registered from the next state so they change with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            resx_r <= 1'b0;
            csx_r  <= 1'b1;
            wrx_r  <= 1'b1;
            busy_r <= 1'b1;
        end else begin
            resx_r <= (state_s != ST_RST_LOW);
            csx_r  <= !((state_s == ST_SETUP) || (state_s == ST_WR_LOW) ||
                        (state_s == ST_WR_HIGH));
            wrx_r  <= (state_s != ST_WR_LOW);
            busy_r <= (state_s != ST_IDLE);
        end
    end

    // Data and DCX captured on accept and held until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_r   <= 16'h0000;
            dcx_r <= LCD_DCX_DATA;
        end else if (cmd_fire_s) begin
            d_r   <= cmd_data;
            dcx_r <= cmd_dcx;
        end else if (pix_fire_s) begin
            d_r   <= pix_data;
            dcx_r <= LCD_DCX_DATA;
        end else begin
            d_r   <= d_r;
            dcx_r <= dcx_r;
        end
    end

    assign lcd_resx = resx_r;
    assign lcd_csx  = csx_r;
    assign lcd_wrx  = wrx_r;
    assign lcd_dcx  = dcx_r;
    assign lcd_d    = d_r;
    assign busy     = busy_r;

endmodule
